// File: rtl/dffrsnq_init_seq_pkg.sv
// Shared types and constants for the dffrsnq bank init sequencer.
package dffrsnq_init_seq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE   = 2'd1,
        RECOVER = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int CNT_W           = 8;
    localparam int PULSE_CYC_MIN   = 1;
    localparam int PULSE_CYC_MAX   = 255;
    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

    // Saturating decrement: the counter parks at zero instead of wrapping.
    function automatic logic [CNT_W-1:0] cnt_dec(input logic [CNT_W-1:0] cnt);
        return (cnt == '0) ? cnt : cnt - CNT_W'(1);
    endfunction

endpackage

// File: rtl/dffrsnq_rst_sync.sv
// Synchronizer chain asynchronously cleared by RN; used for reset release and,
// optionally, for the init request.
module dffrsnq_rst_sync #(
    parameter int STAGES = 2
) (
    input  logic CLK,
    input  logic RN,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] chain_q;

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/dffrsnq_init_seq.sv
// Init-pulse sequencer for a dffrsnq bank: one set or reset pulse per request.
// Optional macro DFFRSNQ_INIT_SEQ_REQ_SYNC_EN adds a 2-flop init_req synchronizer.
//
// state   | meaning
// IDLE    | waiting for an init_req rising edge
// PULSE   | driving RN_O or SETN_O low for PULSE_CYC cycles
// RECOVER | both outputs high for SYNC_STAGES cycles
// DONE    | one-cycle done pulse, then back to IDLE
module dffrsnq_init_seq #(
    parameter int PULSE_CYC   = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RN,
    input  logic init_req,
    input  logic init_val,
    output logic RN_O,
    output logic SETN_O,
    output logic busy,
    output logic done
);
    import dffrsnq_init_seq_pkg::*;

    if (PULSE_CYC < PULSE_CYC_MIN || PULSE_CYC > PULSE_CYC_MAX) begin : g_bad_pulse
        $error("PULSE_CYC out of range");
    end
    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
        $error("SYNC_STAGES out of range");
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             val_q, val_d;
    logic             req_prev_q;
    logic             rn_pulse_q, setn_q;
    logic             rel_q;
    logic             req_s;
    logic             req_edge;

    dffrsnq_rst_sync #(.STAGES(SYNC_STAGES)) u_rel_sync (
        .CLK (CLK),
        .RN  (RN),
        .d_i (1'b1),
        .q_o (rel_q)
    );

`ifdef DFFRSNQ_INIT_SEQ_REQ_SYNC_EN
    dffrsnq_rst_sync #(.STAGES(2)) u_req_sync (
        .CLK (CLK),
        .RN  (RN),
        .d_i (init_req),
        .q_o (req_s)
    );
`else
    assign req_s = init_req;
`endif

    // The edge detector keeps tracking while busy, so a held request never retriggers.
    assign req_edge = req_s & ~req_prev_q & rel_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        val_d   = val_q;
        unique case (state_q)
            IDLE: begin
                if (req_edge) begin
                    val_d   = init_val;
                    cnt_d   = CNT_W'(PULSE_CYC - 1);
                    state_d = PULSE;
                end
            end
            PULSE: begin
                if (cnt_q == '0) begin
                    cnt_d   = CNT_W'(SYNC_STAGES - 1);
                    state_d = RECOVER;
                end else begin
                    cnt_d = cnt_dec(cnt_q);
                end
            end
            RECOVER: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_dec(cnt_q);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            val_q      <= 1'b0;
            req_prev_q <= 1'b0;
            rn_pulse_q <= 1'b1;
            setn_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            val_q      <= val_d;
            req_prev_q <= req_s;
            rn_pulse_q <= ~((state_d == PULSE) & ~val_d);
            setn_q     <= ~((state_d == PULSE) & val_d);
        end
    end

    // rel_q is static once released, so this AND of two flops cannot glitch.
    assign RN_O   = rel_q & rn_pulse_q;
    assign SETN_O = setn_q;
    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);

endmodule

// File: tb/tb_dffrsnq_init_seq.sv
// Scoreboard bench for dffrsnq_init_seq: a cycle-remaining model pushes expected
// completions, a negedge monitor checks outputs and pops on done.
module tb_dffrsnq_init_seq;

    localparam int P = 4;
    localparam int S = 2;
    localparam int L = P + S + 1;
`ifdef DFFRSNQ_INIT_SEQ_REQ_SYNC_EN
    localparam int REQ_LAT = 2;
`else
    localparam int REQ_LAT = 0;
`endif

    logic CLK, RN, init_req, init_val;
    logic RN_O, SETN_O, busy, done;

    dffrsnq_init_seq #(.PULSE_CYC(P), .SYNC_STAGES(S)) dut (
        .CLK      (CLK),
        .RN       (RN),
        .init_req (init_req),
        .init_val (init_val),
        .RN_O     (RN_O),
        .SETN_O   (SETN_O),
        .busy     (busy),
        .done     (done)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        int   cyc;
        logic val;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // Reference model: m_rem counts cycles left until the sequence returns to idle.
    int   m_rem = 0;
    int   m_rel = 0;
    int   m_completed = 0;
    logic m_prev = 1'b0;
    logic m_val = 1'b0;
    logic m_s1 = 1'b0;
    logic m_s2 = 1'b0;

    always @(posedge CLK or negedge RN) begin
        logic req_s;
        logic acc;
        if (!RN) begin
            if (m_rem != 0 && sb.size() != 0) void'(sb.pop_back());
            m_rem  = 0;
            m_rel  = 0;
            m_prev = 1'b0;
            m_s1   = 1'b0;
            m_s2   = 1'b0;
        end else begin
`ifdef DFFRSNQ_INIT_SEQ_REQ_SYNC_EN
            req_s = m_s2;
            m_s2  = m_s1;
            m_s1  = init_req;
`else
            req_s = init_req;
`endif
            acc    = (m_rem == 0) && (m_rel >= S) && req_s && !m_prev;
            m_prev = req_s;
            if (m_rem != 0) begin
                if (m_rem == 1) m_completed++;
                m_rem--;
            end else if (acc) begin
                m_rem = L;
                m_val = init_val;
                sb.push_back('{cyc: cyc + L, val: init_val});
            end
            if (m_rel < 15) m_rel++;
        end
    end

    int   total_done = 0;
    int   last_done_cyc = 0;
    int   mon_setn_low = 0;
    int   mon_rn_low = 0;
    int   mon_busy = 0;
    logic mon_kind = 1'b0;

    always @(negedge CLK) begin
        logic pulse, exp_rn, exp_setn;
        exp_t item;
        pulse    = (m_rem >= S + 2);
        exp_rn   = (m_rel >= S) && !(pulse && !m_val);
        exp_setn = !(pulse && m_val);
        check("rn_o", RN_O, exp_rn);
        check("setn_o", SETN_O, exp_setn);
        check("busy", busy, m_rem != 0);
        check("done", done, m_rem == 1);
        check("mutex", (!RN_O && !SETN_O), 0);
        if (!SETN_O) mon_setn_low++;
        if (!RN_O) mon_rn_low++;
        if (busy) mon_busy++;
        if (busy && !SETN_O) mon_kind = 1'b1;
        if (busy && !RN_O) mon_kind = 1'b0;
        if (done) begin
            total_done++;
            last_done_cyc = cyc;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL done_unexpected: got done=1, expected no pending sequence (cycle %0d)", cyc);
            end else begin
                item = sb.pop_front();
                check("done_cycle", cyc, item.cyc);
                check("done_kind", mon_kind, item.val);
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int w_setn, w_rn, w_busy, w_done, t0;
        RN = 1'b0;
        init_req = 1'b0;
        init_val = 1'b0;

        // Reset and release
        repeat (3) step();
        check("rst_rn_o", RN_O, 0);
        check("rst_setn_o", SETN_O, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        RN = 1'b1;
        step();
        check("rel_edge1_rn_o", RN_O, 0);
        step();
        check("rel_edge2_rn_o", RN_O, 1);
        check("rel_setn_o", SETN_O, 1);
        repeat (2) step();

        // Set pulse, request held high
        w_setn = mon_setn_low; w_rn = mon_rn_low; w_busy = mon_busy; w_done = total_done;
        t0 = cyc;
        init_val = 1'b1;
        init_req = 1'b1;
        repeat (10) step();
        init_req = 1'b0;
        repeat (4) step();
        check("set_width", mon_setn_low - w_setn, 4);
        check("set_rn_low", mon_rn_low - w_rn, 0);
        check("set_busy_cycles", mon_busy - w_busy, 7);
        check("set_done_count", total_done - w_done, 1);
        check("set_done_latency", last_done_cyc - t0, 7 + REQ_LAT);

        // Reset pulse with a second edge while busy
        w_setn = mon_setn_low; w_rn = mon_rn_low; w_done = total_done;
        init_val = 1'b0;
        init_req = 1'b1;
        repeat (2) step();
        init_req = 1'b0;
        step();
        init_req = 1'b1;
        repeat (16) step();
        init_req = 1'b0;
        repeat (2) step();
        check("busy_drop_rn_width", mon_rn_low - w_rn, 4);
        check("busy_drop_setn_low", mon_setn_low - w_setn, 0);
        check("busy_drop_done_count", total_done - w_done, 1);

        // Abort in the second pulse cycle of a set sequence
        w_done = total_done;
        init_val = 1'b1;
        init_req = 1'b1;
        repeat (2 + REQ_LAT) step();
        check("abort_pre_setn_o", SETN_O, 0);
        RN = 1'b0;
        #1;
        check("abort_setn_o", SETN_O, 1);
        check("abort_rn_o", RN_O, 0);
        check("abort_busy", busy, 0);
        step();
        init_req = 1'b0;
        step();
        RN = 1'b1;
        repeat (10) step();
        check("abort_done_count", total_done - w_done, 0);

        // Random stimulus
        for (int i = 0; i < 200; i++) begin
            init_req = 1'($urandom_range(0, 1));
            init_val = 1'($urandom_range(0, 1));
            RN = ($urandom_range(0, 29) == 0) ? 1'b0 : 1'b1;
            step();
        end
        RN = 1'b1;
        init_req = 1'b0;
        repeat (20) step();
        check("rand_done_vs_completed", total_done, m_completed);
        check("scoreboard_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
